// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: ASCII bytes, status and mode
// encodings, and the result transmitter's FSM states.
package calc_pkg;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_V     = 8'h56;
  localparam logic [7:0] CH_F     = 8'h46;

  typedef enum logic [1:0] {
    NOT_COMPLETE = 2'd0,
    COMPLETE     = 2'd1,
    INVALID      = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    MODE_SIN   = 2'd0,
    MODE_COS   = 2'd1,
    MODE_PRIME = 2'd2,
    MODE_SQRT  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {IDLE, CONV, LOAD, SEND, DONE} state_e;

  typedef enum logic [1:0] {MSG_NUM, MSG_ERR, MSG_OVF} msg_e;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return CH_0 | {4'h0, d};
  endfunction

endpackage

// File: rtl/result_ascii_tx_if.sv
// Request side (start/status/value) and UART byte stream of result_ascii_tx.
interface result_ascii_tx_if;
  logic        start;
  logic [1:0]  status;
  logic [15:0] value;
  logic        frac_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  modport master (
    output start, status, value, frac_en, tx_ready,
    input  tx_data, tx_valid, busy, done
  );

  modport slave (
    input  start, status, value, frac_en, tx_ready,
    output tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 14-bit binary to 4 BCD digits, one shift per cycle.
// The first shift happens on the start edge, so done pulses 14 cycles after start.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        done
);

  logic [13:0] sh_q;
  logic [3:0]  cnt_q;
  logic        run_q;
  logic [11:0] adj;

  // The thousands digit is at most 4 before the last shift, so it never needs the +3.
  always_comb begin
    adj = bcd[11:0];
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd   <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd   <= {15'd0, bin[13]};
        sh_q  <= {bin[12:0], 1'b0};
        cnt_q <= 4'd13;
        run_q <= 1'b1;
      end else if (run_q) begin
        bcd   <= {bcd[14:12], adj, sh_q[13]};
        sh_q  <= {sh_q[12:0], 1'b0};
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/result_ascii_tx.sv
// Formats a signed calculator result (or ERR/OVF) as an ASCII line ending in
// CR LF and streams it byte by byte over a valid/ready handshake.
module result_ascii_tx
  import calc_pkg::*;
#(
  parameter int FRAC_DIGITS = 3,
  parameter int MAX_MAG     = 9999
) (
  input logic               clk,
  input logic               rst_n,
  result_ascii_tx_if.slave  bus
);

  localparam logic [15:0] MAX_MAG_W = 16'(MAX_MAG);

  state_e      state_q;
  msg_e        msg_q;
  logic        neg_q;
  logic        frac_q;
  logic [7:0]  buf_q [8];
  logic [3:0]  len_q;
  logic [2:0]  idx_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] mag;
  logic        bcd_start;
  logic [15:0] bcd;
  logic        bcd_done;

  logic [7:0]  asm_buf [8];
  logic [3:0]  asm_len;
  logic [3:0]  n;
  logic [3:0]  d;
  logic        seen;

  // -32768 stays 0x8000 here, which is above any legal MAX_MAG and prints OVF.
  assign mag       = bus.value[15] ? (~bus.value + 16'd1) : bus.value;
  assign bcd_start = (state_q == IDLE) && bus.start && (bus.status == COMPLETE) &&
                     (mag <= MAX_MAG_W);

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bcd_start),
    .bin   (mag[13:0]),
    .bcd   (bcd),
    .done  (bcd_done)
  );

  // NOTE: blocking assignments are required here; n is a write pointer that
  // advances within a single evaluation of the block.
  always_comb begin
    asm_buf = '{default: 8'h00};
    n       = 4'd0;
    d       = 4'd0;
    seen    = 1'b0;
    case (msg_q)
      MSG_ERR: begin
        asm_buf[0] = CH_E; asm_buf[1] = CH_R; asm_buf[2] = CH_R;
        n = 4'd3;
      end
      MSG_OVF: begin
        asm_buf[0] = CH_O; asm_buf[1] = CH_V; asm_buf[2] = CH_F;
        n = 4'd3;
      end
      default: begin
        if (neg_q) begin
          asm_buf[0] = CH_MINUS;
          n = 4'd1;
        end
        for (int i = 3; i >= 0; i--) begin
          d = bcd[i*4 +: 4];
          if (frac_q && (i < FRAC_DIGITS)) begin
            if (i == FRAC_DIGITS - 1) begin
              asm_buf[n[2:0]] = CH_DOT;
              n = n + 4'd1;
            end
            asm_buf[n[2:0]] = ascii_digit(d);
            n = n + 4'd1;
          end else if ((d != 4'd0) || seen || (i == (frac_q ? FRAC_DIGITS : 0))) begin
            asm_buf[n[2:0]] = ascii_digit(d);
            n    = n + 4'd1;
            seen = 1'b1;
          end
        end
      end
    endcase
    asm_buf[n[2:0]]        = CH_CR;
    asm_buf[n[2:0] + 3'd1] = CH_LF;
    asm_len                = n + 4'd2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      msg_q      <= MSG_NUM;
      neg_q      <= 1'b0;
      frac_q     <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      // NOTE: the frame buffer is cleared too, so an aborted frame leaves nothing behind.
      buf_q      <= '{default: 8'h00};
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && (bus.status != NOT_COMPLETE)) begin
            neg_q  <= bus.value[15];
            frac_q <= bus.frac_en;
            busy_q <= 1'b1;
            if (bus.status[1]) begin
              msg_q   <= MSG_ERR;
              state_q <= LOAD;
            end else if (mag > MAX_MAG_W) begin
              msg_q   <= MSG_OVF;
              state_q <= LOAD;
            end else begin
              msg_q   <= MSG_NUM;
              state_q <= CONV;
            end
          end
        end
        CONV: if (bcd_done) state_q <= LOAD;
        LOAD: begin
          buf_q      <= asm_buf;
          len_q      <= asm_len;
          idx_q      <= '0;
          tx_data_q  <= asm_buf[0];
          tx_valid_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          if (bus.tx_ready) begin
            if ({1'b0, idx_q} == len_q - 4'd1) begin
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              idx_q     <= idx_q + 3'd1;
              tx_data_q <= buf_q[idx_q + 3'd1];
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_result_ascii_tx.sv
// Randomized self-checking bench for result_ascii_tx against a string-level
// reference of the printed line, including timing, back-pressure and reset.
module tb_result_ascii_tx;

  logic clk;
  logic rst_n;
  result_ascii_tx_if bus ();

  result_ascii_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int abs_of(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected line from the printing rules; empty when the request is ignored.
  function automatic void build_expected(input int st, input int v, input bit fr);
    string s;
    int mag, ip;
    exp_q.delete();
    mag = abs_of(v);
    if (st == 0) return;
    if (st >= 2) begin
      exp_q.push_back("E"); exp_q.push_back("R"); exp_q.push_back("R");
    end else if (mag > 9999) begin
      exp_q.push_back("O"); exp_q.push_back("V"); exp_q.push_back("F");
    end else begin
      if (v < 0) exp_q.push_back(8'h2D);
      ip = fr ? mag / 1000 : mag;
      s  = $sformatf("%0d", ip);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      if (fr) begin
        exp_q.push_back(8'h2E);
        exp_q.push_back(8'(48 + (mag / 100) % 10));
        exp_q.push_back(8'(48 + (mag / 10) % 10));
        exp_q.push_back(8'(48 + mag % 10));
      end
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic quiet(input int cycles);
    int nv = 0;
    int nb = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.tx_valid) nv++;
      if (bus.busy) nb++;
    end
    check("idle_valid", nv, 0);
    check("idle_busy", nb, 0);
  endtask

  // Cycle 0 is the negedge where start is driven; inputs set at a negedge are
  // sampled at the following posedge, outputs read at a negedge are that cycle's.
  task automatic run_frame(input int st, input int v, input bit fr, input bit bp,
                           input bit noise, input int rst_after);
    int  c = 0, nx = 0, first_c = -1, last_c = -1, rst_stage = 0;
    int  exp_first;
    bit  fin = 0, prev_stall = 0;
    logic [7:0] prev_data = '0;
    build_expected(st, v, fr);
    exp_first = (st == 1 && abs_of(v) <= 9999) ? 16 : 2;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.status   = st[1:0];
    bus.value    = v[15:0];
    bus.frac_en  = fr;
    bus.tx_ready = 1'b1;
    if (exp_q.size() == 0) begin
      quiet(20);
      return;
    end
    while (!fin) begin
      @(negedge clk);
      c++;
      bus.start = 1'b0;
      if (noise) begin
        bus.value   = 16'($urandom);
        bus.status  = 2'($urandom);
        bus.frac_en = 1'($urandom);
        bus.start   = ($urandom_range(0, 3) == 0);
      end
      if (rst_stage == 2) begin
        check("rst_valid", bus.tx_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_data", bus.tx_data, 0);
        rst_n = 1'b1;
        fin   = 1;
      end else if (rst_stage == 1) begin
        rst_n     = 1'b0;
        rst_stage = 2;
      end else begin
        if (c == 1) check("busy_c1", bus.busy, 1);
        if (prev_stall) check("stall_hold", bus.tx_data, prev_data);
        if (first_c < 0 && bus.tx_valid) begin
          first_c = c;
          check("first_valid", c, exp_first);
        end
        if (first_c >= 0 && nx < exp_q.size()) check("valid_hold", bus.tx_valid, 1);
        if (bus.done) begin
          check("done_cycle", c, last_c + 1);
          check("frame_len", nx, exp_q.size());
          if (noise) begin
            bus.start  = 1'b1;
            bus.status = 2'd1;
            bus.value  = 16'd123;
          end
          fin = 1;
        end else if (c > 600) begin
          check("timeout", c, 0);
          fin = 1;
        end else begin
          bus.tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
          if (bus.tx_valid && bus.tx_ready) begin
            if (nx < exp_q.size()) check("byte", bus.tx_data, exp_q[nx]);
            else check("extra_byte", nx, exp_q.size() - 1);
            nx++;
            last_c = c;
            if (nx == rst_after) rst_stage = 1;
          end
          prev_stall = bus.tx_valid && !bus.tx_ready;
          prev_data  = bus.tx_data;
        end
      end
    end
    if (rst_after == 0) quiet(4);
  endtask

  initial begin
    int v;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.status   = 2'd0;
    bus.value    = 16'd0;
    bus.frac_en  = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", bus.tx_data, 0);
    check("reset_valid", bus.tx_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    rst_n = 1'b1;

    run_frame(1, 360, 0, 0, 0, 0);
    run_frame(1, -707, 1, 0, 0, 0);
    run_frame(1, 0, 0, 0, 0, 0);
    run_frame(1, 5, 1, 0, 0, 0);
    run_frame(2, 123, 0, 0, 0, 0);
    run_frame(3, -1, 1, 0, 0, 0);
    run_frame(1, 12000, 0, 0, 0, 0);
    run_frame(1, -32768, 0, 0, 0, 0);
    run_frame(1, 10000, 1, 0, 0, 0);
    run_frame(0, 55, 0, 0, 0, 0);
    run_frame(1, -9999, 0, 0, 0, 0);
    run_frame(1, 9999, 0, 1, 1, 0);
    run_frame(1, 9999, 1, 1, 1, 0);
    run_frame(1, 4321, 0, 0, 0, 3);
    run_frame(1, 4321, 0, 0, 0, 0);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 24000)) - 12000;
      else v = int'($signed(16'($urandom)));
      run_frame(int'($urandom_range(0, 3)), v, 1'($urandom), 1'($urandom), 1'($urandom), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
